// File: rtl/data_ram_ctrl_pkg.sv
// Shared constants and FSM encoding for the data RAM controller.
package data_ram_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dram_sram_1rw.sv
// Single-port DEPTH x XLEN array: byte-enabled write, registered read on load accesses only.
module dram_sram_1rw
    import data_ram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [STRB_W-1:0] i_be,
    input  logic [AW-1:0]     i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN-1:0]   o_rdata
);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [XLEN-1:0] r_q;

    // The read register only moves on loads, so stores never disturb o_rdata.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end else if (i_en) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller for the MEM stage: store-in-accept-cycle, fixed-latency loads with
// held response, flush and back-to-back support.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH        = 4096,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              dram_req,
    output logic              dram_ready,
    input  logic              dram_write,
    input  logic [XLEN-1:0]   dram_addr,
    input  logic [XLEN-1:0]   dram_wdata,
    input  logic [STRB_W-1:0] dram_strobe,
    output logic              dram_rvalid,
    output logic [XLEN-1:0]   dram_rdata,
    input  logic              dram_rready,
    input  logic              dram_flush
);

    localparam int unsigned      AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(READ_LATENCY - 1);
    localparam state_t           LOAD_ST = (READ_LATENCY == 1) ? ST_RESP : ST_WAIT;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rvalid;
    logic             r_capture;
    logic [XLEN-1:0]  r_rdata;
    logic [XLEN-1:0]  w_q;
    logic             w_accept;
    logic             w_load;
    logic             w_unused_addr;

    assign dram_ready = rst_b & ~dram_flush &
                        ((r_state == ST_IDLE) | ((r_state == ST_RESP) & dram_rready));
    assign w_accept   = dram_req & dram_ready;
    assign w_load     = w_accept & ~dram_write;

    assign w_unused_addr = ^{dram_addr[XLEN-1:AW+2], dram_addr[1:0]};

    dram_sram_1rw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_accept),
        .i_we    (dram_write),
        .i_be    (dram_strobe),
        .i_addr  (dram_addr[AW+1:2]),
        .i_wdata (dram_wdata),
        .o_rdata (w_q)
    );

    // FSM, latency counter and response register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rvalid  <= 1'b0;
            r_capture <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_capture <= w_load;
            if (r_capture) begin
                r_rdata <= w_q;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state  <= LOAD_ST;
                        r_cnt    <= LAT_M1;
                        r_rvalid <= (LOAD_ST == ST_RESP);
                    end
                end
                ST_WAIT: begin
                    if (dram_flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_state  <= ST_RESP;
                        r_cnt    <= '0;
                        r_rvalid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (dram_flush) begin
                        r_state  <= ST_IDLE;
                        r_rvalid <= 1'b0;
                    end else if (dram_rready) begin
                        if (w_load) begin
                            r_state  <= LOAD_ST;
                            r_cnt    <= LAT_M1;
                            r_rvalid <= (LOAD_ST == ST_RESP);
                        end else begin
                            r_state  <= ST_IDLE;
                            r_rvalid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    r_rvalid <= 1'b0;
                end
            endcase
        end
    end

    // Fresh array data is forwarded in the cycle it lands, the held copy afterwards.
    assign dram_rdata  = r_capture ? w_q : r_rdata;
    assign dram_rvalid = r_rvalid;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench: two controllers (latency 1 and 3) on shared stimulus against a
// transaction-level model, plus directed literal checks.
module tb_data_ram_ctrl;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req, wr, rready, flush;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [1:0]  rdy, rv;
    logic [31:0] rd [2];

    int errors = 0;
    int checks = 0;

    logic [31:0] init_data [DEPTH];
    logic [31:0] mmem [2][DEPTH];
    bit          mbusy [2];
    int          mleft [2];
    logic [31:0] mdata [2];

    always #5 clk = ~clk;

    data_ram_ctrl #(.DEPTH(DEPTH), .READ_LATENCY(1)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .dram_req(req), .dram_ready(rdy[0]), .dram_write(wr),
        .dram_addr(addr), .dram_wdata(wdata), .dram_strobe(strb), .dram_rvalid(rv[0]),
        .dram_rdata(rd[0]), .dram_rready(rready), .dram_flush(flush));

    data_ram_ctrl #(.DEPTH(DEPTH), .READ_LATENCY(3)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .dram_req(req), .dram_ready(rdy[1]), .dram_write(wr),
        .dram_addr(addr), .dram_wdata(wdata), .dram_strobe(strb), .dram_rvalid(rv[1]),
        .dram_rdata(rd[1]), .dram_rready(rready), .dram_flush(flush));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Transaction model: a load is outstanding until consumed, flushed or reset.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit erv, erdy, acc;
            int idx;
            if (!rst_b) mbusy[k] = 0;
            erv  = mbusy[k] && (mleft[k] == 0);
            erdy = rst_b && !flush && (!mbusy[k] || (erv && rready));
            check($sformatf("dut%0d ready", k), {31'd0, rdy[k]}, {31'd0, erdy});
            check($sformatf("dut%0d rvalid", k), {31'd0, rv[k]}, {31'd0, erv});
            if (erv) check($sformatf("dut%0d rdata", k), rd[k], mdata[k]);
            if (!rst_b) check($sformatf("dut%0d rdata_rst", k), rd[k], 32'd0);
            if (rst_b) begin
                acc = req && erdy;
                if (mbusy[k]) begin
                    if (flush) mbusy[k] = 0;
                    else if (erv) begin
                        if (rready) mbusy[k] = 0;
                    end else mleft[k] = mleft[k] - 1;
                end
                if (acc) begin
                    idx = int'((addr >> 2) % DEPTH);
                    if (wr) begin
                        for (int b = 0; b < 4; b++)
                            if (strb[b]) mmem[k][idx][8*b +: 8] = wdata[8*b +: 8];
                    end else begin
                        mbusy[k] = 1;
                        mleft[k] = lat(k) - 1;
                        mdata[k] = mmem[k][idx];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [31:0] a);
        req = 1'b1; wr = 1'b0; addr = a;
    endtask

    initial begin
        rst_b = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; strb = '0;
        rready = 1'b1; flush = 1'b0;
        for (int k = 0; k < 2; k++) begin mbusy[k] = 0; mleft[k] = 0; mdata[k] = '0; end
        #2 rst_b = 1'b0;
        tick(); tick();
        rst_b = 1'b1;

        // Fill both arrays so every later load has defined data.
        for (int i = 0; i < DEPTH; i++) begin
            req = 1'b1; wr = 1'b1; addr = 32'(i * 4); wdata = $urandom; strb = 4'hF;
            init_data[i] = wdata;
            tick();
        end
        idle(2);

        // Store then load at latency 1; flush in IDLE blocks acceptance.
        req = 1'b1; wr = 1'b1; addr = 32'h100; wdata = 32'hDEADBEEF; strb = 4'hF;
        tick();
        load(32'h100); flush = 1'b1;
        #1;
        check("flush_idle_ready0", {31'd0, rdy[0]}, 32'd0);
        check("flush_idle_ready1", {31'd0, rdy[1]}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_idle_no_rvalid", {31'd0, rv[0]}, 32'd0);
        #1;
        check("idle_ready0", {31'd0, rdy[0]}, 32'd1);
        tick();
        req = 1'b0;
        check("l1_rvalid", {31'd0, rv[0]}, 32'd1);
        check("l1_rdata", rd[0], 32'hDEADBEEF);
        idle(4);

        // Reset while the latency-3 load sits in WAIT; memory survives.
        load(32'h100);
        tick();
        req = 1'b0;
        tick();
        rst_b = 1'b0;
        #1;
        check("rst_rvalid1", {31'd0, rv[1]}, 32'd0);
        check("rst_ready1", {31'd0, rdy[1]}, 32'd0);
        check("rst_rdata1", rd[1], 32'd0);
        tick(); tick();
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("post_rst_no_rvalid1", {31'd0, rv[1]}, 32'd0);
            tick();
        end
        load(32'h100);
        tick();
        req = 1'b0;
        check("post_rst_rdata0", rd[0], 32'hDEADBEEF);
        tick(); tick();
        check("post_rst_rvalid1", {31'd0, rv[1]}, 32'd1);
        check("post_rst_rdata1", rd[1], 32'hDEADBEEF);
        idle(3);

        // Partial store: byte 0xAA placed in lane 1, then load from an unaligned address.
        req = 1'b1; wr = 1'b1; addr = 32'h100; wdata = 32'h0000AA00; strb = 4'h2;
        tick();
        load(32'h103);
        tick();
        req = 1'b0;
        check("partial_rvalid0", {31'd0, rv[0]}, 32'd1);
        check("partial_rdata0", rd[0], 32'hDEADAAEF);
        check("model_partial", mmem[0][64], 32'hDEADAAEF);
        idle(4);

        // Latency 3 with rready held low for four response cycles.
        rready = 1'b0;
        load(32'h100);
        tick();
        req = 1'b0;
        check("l3_wait_a", {31'd0, rv[1]}, 32'd0);
        tick();
        check("l3_wait_b", {31'd0, rv[1]}, 32'd0);
        tick();
        check("l3_rvalid", {31'd0, rv[1]}, 32'd1);
        check("l3_rdata", rd[1], 32'hDEADAAEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("l3_hold_rvalid", {31'd0, rv[1]}, 32'd1);
            check("l3_hold_rdata", rd[1], 32'hDEADAAEF);
            check("l3_hold_ready", {31'd0, rdy[1]}, 32'd0);
        end
        rready = 1'b1;
        #1;
        check("l3_ready_on_rready", {31'd0, rdy[1]}, 32'd1);
        tick();
        check("l3_done", {31'd0, rv[1]}, 32'd0);
        idle(3);

        // Flush one cycle after accept kills the latency-3 load.
        load(32'h100);
        tick();
        req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("flushed_no_rvalid1", {31'd0, rv[1]}, 32'd0);
            tick();
        end
        load(32'h8);
        tick();
        req = 1'b0;
        tick(); tick();
        check("after_flush_rvalid1", {31'd0, rv[1]}, 32'd1);
        check("after_flush_rdata1", rd[1], init_data[2]);
        idle(3);

        // Back-to-back loads at latency 1.
        load(32'h0);
        tick();
        load(32'h4);
        #1;
        check("b2b_ready", {31'd0, rdy[0]}, 32'd1);
        check("b2b_first_rvalid", {31'd0, rv[0]}, 32'd1);
        check("b2b_first_rdata", rd[0], init_data[0]);
        tick();
        req = 1'b0;
        check("b2b_second_rvalid", {31'd0, rv[0]}, 32'd1);
        check("b2b_second_rdata", rd[0], init_data[1]);
        tick();
        check("b2b_end", {31'd0, rv[0]}, 32'd0);
        idle(4);

        // Randomized traffic including wrap-around addresses, flushes and resets.
        for (int i = 0; i < 2000; i++) begin
            rst_b  = ($urandom_range(0, 199) != 0);
            req    = ($urandom_range(0, 2) != 0);
            wr     = $urandom_range(0, 1) == 1;
            addr   = $urandom & 32'h0000_0FFF;
            wdata  = $urandom;
            strb   = 4'($urandom);
            rready = ($urandom_range(0, 9) < 7);
            flush  = ($urandom_range(0, 11) == 0);
            tick();
        end
        rst_b = 1'b1; flush = 1'b0; rready = 1'b1;
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
